// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-flow logic: FSM encoding, the blank
// digit code, a digit helper and the score-digit placement on screen.
package pong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PAUSE = 2'd1,
      ST_PLAY  = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   // Code that makes a digit renderer draw nothing
   localparam logic [3:0] BLANK_DIGIT = 4'hF;

   // Score-digit geometry (640x480 visible area)
   localparam int SCREEN_W     = 640;
   localparam int DIGIT_W      = 24;
   localparam int DIGIT_H      = 40;
   localparam int DIGIT_TOP    = 16;
   localparam int DIGIT_GAP    = 64;
   localparam int DIGIT_LEFT_X  = SCREEN_W / 2 - DIGIT_GAP - DIGIT_W;
   localparam int DIGIT_RIGHT_X = SCREEN_W / 2 + DIGIT_GAP;
   localparam int DIGIT_BOTTOM  = DIGIT_TOP + DIGIT_H;

   // Value handed to a renderer: the score, or blank while hidden
   function automatic logic [3:0] digit_value(input logic [3:0] score,
                                              input logic       blank);
      return blank ? BLANK_DIGIT : score;
   endfunction

endpackage

// File: rtl/score_controller_if.sv
// Game-flow bus: event pulses into the score controller and the digit /
// ball-control signals it drives back out.
interface score_controller_if;
   logic       frame_tick;
   logic       start;
   logic       point_left;
   logic       point_right;
   logic [3:0] num_left;
   logic [3:0] num_right;
   logic       ball_freeze;
   logic       serve;
   logic       serve_dir;
   logic       game_over;
   logic       winner;

   // Side that generates events and consumes the controls
   modport master (
      output frame_tick, start, point_left, point_right,
      input  num_left, num_right, ball_freeze, serve, serve_dir,
             game_over, winner
   );

   // The score controller itself
   modport slave (
      input  frame_tick, start, point_left, point_right,
      output num_left, num_right, ball_freeze, serve, serve_dir,
             game_over, winner
   );
endinterface

// File: rtl/score_controller_frame_timer.sv
// Loadable 8-bit frame_tick counter. Counts down to zero, or up to LIMIT and
// wraps to zero; o_term flags the tick that finishes a period.
module frame_timer #(
   parameter bit         COUNT_UP = 1'b0,
   parameter logic [7:0] LIMIT    = 8'd1
) (
   input  logic       clk_0,
   input  logic       rst,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   input  logic       i_en,
   input  logic       i_tick,
   output logic       o_term
);

   logic [7:0] r_count;
   logic [7:0] w_inc;
   logic       w_step;

   assign w_inc  = r_count + 8'd1;
   assign w_step = i_en & i_tick;
   assign o_term = w_step & (COUNT_UP ? (w_inc == LIMIT) : (r_count == 8'd1));

   // Counter register: a load beats a coincident tick, so state-entry ticks are lost
   always_ff @(posedge clk_0) begin
      if (!rst) begin
         r_count <= 8'd0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (w_step) begin
         if (COUNT_UP) begin
            r_count <= o_term ? 8'd0 : w_inc;
         end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
         end
      end
   end

endmodule

// File: rtl/score_controller.sv
// Pong game-flow sequencer: scores, post-point pause, serve, winner blink.
// Every output is registered from the next-state values computed below.
module score_controller
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 7,
   parameter int PAUSE_FRAMES = 60,
   parameter int BLINK_FRAMES = 15
) (
   input  logic              clk_0,
   input  logic              rst,
   score_controller_if.slave bus
);

   localparam logic [3:0] L_WIN   = 4'(WIN_SCORE);
   localparam logic [7:0] L_PAUSE = 8'(PAUSE_FRAMES);
   localparam logic [7:0] L_BLINK = 8'(BLINK_FRAMES);

   state_t     r_state;
   logic [3:0] r_score_l;
   logic [3:0] r_score_r;
   logic [3:0] r_num_left;
   logic [3:0] r_num_right;
   logic       r_ball_freeze;
   logic       r_serve;
   logic       r_serve_dir;
   logic       r_game_over;
   logic       r_winner;
   logic       r_blink_phase;

   state_t     w_state_nxt;
   logic [3:0] w_score_l_nxt;
   logic [3:0] w_score_r_nxt;
   logic       w_serve_nxt;
   logic       w_dir_nxt;
   logic       w_winner_nxt;
   logic       w_phase_nxt;
   logic       w_pause_load;
   logic       w_blink_clear;
   logic       w_pause_term;
   logic       w_blink_term;
   logic       w_blank_l;
   logic       w_blank_r;

   // Pause timer: counts frames down while the ball waits at centre
   frame_timer #(.COUNT_UP(1'b0), .LIMIT(8'd1)) u_pause_timer (
      .clk_0      (clk_0),
      .rst        (rst),
      .i_load     (w_pause_load),
      .i_load_val (L_PAUSE),
      .i_en       (r_state == ST_PAUSE),
      .i_tick     (bus.frame_tick),
      .o_term     (w_pause_term)
   );

   // Blink timer: a start in OVER swallows a coincident tick
   frame_timer #(.COUNT_UP(1'b1), .LIMIT(L_BLINK)) u_blink_timer (
      .clk_0      (clk_0),
      .rst        (rst),
      .i_load     (w_blink_clear),
      .i_load_val (8'd0),
      .i_en       ((r_state == ST_OVER) && !bus.start),
      .i_tick     (bus.frame_tick),
      .o_term     (w_blink_term)
   );

   // State register
   always_ff @(posedge clk_0) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic and next values of scores, serve and blink
   always_comb begin
      w_state_nxt   = r_state;
      w_score_l_nxt = r_score_l;
      w_score_r_nxt = r_score_r;
      w_serve_nxt   = 1'b0;
      w_dir_nxt     = r_serve_dir;
      w_winner_nxt  = r_winner;
      w_phase_nxt   = r_blink_phase;
      w_pause_load  = 1'b0;
      w_blink_clear = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt   = ST_PAUSE;
               w_score_l_nxt = 4'd0;
               w_score_r_nxt = 4'd0;
               w_dir_nxt     = 1'b0;
               w_pause_load  = 1'b1;
            end
         end
         ST_PAUSE: begin
            if (w_pause_term) begin
               w_state_nxt = ST_PLAY;
               w_serve_nxt = 1'b1;
            end
         end
         ST_PLAY: begin
            // Left has priority when both players score in the same cycle
            if (bus.point_left) begin
               w_score_l_nxt = r_score_l + 4'd1;
               if (w_score_l_nxt == L_WIN) begin
                  w_state_nxt   = ST_OVER;
                  w_winner_nxt  = 1'b0;
                  w_blink_clear = 1'b1;
                  w_phase_nxt   = 1'b0;
               end else begin
                  w_state_nxt  = ST_PAUSE;
                  w_pause_load = 1'b1;
                  w_dir_nxt    = 1'b1;
               end
            end else if (bus.point_right) begin
               w_score_r_nxt = r_score_r + 4'd1;
               if (w_score_r_nxt == L_WIN) begin
                  w_state_nxt   = ST_OVER;
                  w_winner_nxt  = 1'b1;
                  w_blink_clear = 1'b1;
                  w_phase_nxt   = 1'b0;
               end else begin
                  w_state_nxt  = ST_PAUSE;
                  w_pause_load = 1'b1;
                  w_dir_nxt    = 1'b0;
               end
            end
         end
         ST_OVER: begin
            if (bus.start) begin
               w_state_nxt   = ST_PAUSE;
               w_score_l_nxt = 4'd0;
               w_score_r_nxt = 4'd0;
               w_pause_load  = 1'b1;
            end else if (w_blink_term) begin
               w_phase_nxt = ~r_blink_phase;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_blank_l = (w_state_nxt == ST_OVER) && !w_winner_nxt && w_phase_nxt;
   assign w_blank_r = (w_state_nxt == ST_OVER) &&  w_winner_nxt && w_phase_nxt;

   // Output and datapath registers
   always_ff @(posedge clk_0) begin
      if (!rst) begin
         r_score_l     <= 4'd0;
         r_score_r     <= 4'd0;
         r_num_left    <= 4'd0;
         r_num_right   <= 4'd0;
         r_ball_freeze <= 1'b1;
         r_serve       <= 1'b0;
         r_serve_dir   <= 1'b0;
         r_game_over   <= 1'b0;
         r_winner      <= 1'b0;
         r_blink_phase <= 1'b0;
      end else begin
         r_score_l     <= w_score_l_nxt;
         r_score_r     <= w_score_r_nxt;
         r_num_left    <= digit_value(w_score_l_nxt, w_blank_l);
         r_num_right   <= digit_value(w_score_r_nxt, w_blank_r);
         r_ball_freeze <= (w_state_nxt != ST_PLAY);
         r_serve       <= w_serve_nxt;
         r_serve_dir   <= w_dir_nxt;
         r_game_over   <= (w_state_nxt == ST_OVER);
         r_winner      <= w_winner_nxt;
         r_blink_phase <= w_phase_nxt;
      end
   end

   assign bus.num_left    = r_num_left;
   assign bus.num_right   = r_num_right;
   assign bus.ball_freeze = r_ball_freeze;
   assign bus.serve       = r_serve;
   assign bus.serve_dir   = r_serve_dir;
   assign bus.game_over   = r_game_over;
   assign bus.winner      = r_winner;

endmodule
